dispatch_3: RTL and testbench

// - Clocked 1-to-3 request fork: one 4-phase req/ack channel from issue, steered by opcode to
//   one of three execution channels; 4-phase ack returned upstream.
// - Inverse of the 3-to-1 merge that returns completions from the same three channels.
// - Channel 1 = branch/jump (B_type 1100011, J_type 1101111).
// - Channel 2 = store (S_type 0100011).
// - Channel 3 = ALU/load (R_type 0110011, I_type_op 0010011, I_type_ld 0000011, NOP 0000000).

---
 rtl/dispatch_3.sv | 187 ++++++++++++++++++
 tb/tb_dispatch_3.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_3.sv
// dispatch_3: clocked 1-to-3 four-phase request fork.
// A single upstream req/ack channel is steered by opcode to one of three execution
// channels:
//   - channel 1: branch/jump
//   - channel 2: store
//   - channel 3: ALU/load/NOP
// Unrecognised opcodes are acknowledged locally and flagged on the illegal output.
// Each channel keeps a count of its completed dispatches.
// Optional feature macro: DISPATCH_SYNC_EN. When defined, req_in and ack_in_1/2/3 each
// pass through a 2-flop synchroniser before the FSM uses them.
module dispatch_3 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             req_in,
  output logic             ack_out,
  output logic             req_out_1,
  output logic             req_out_2,
  output logic             req_out_3,
  input  logic             ack_in_1,
  input  logic             ack_in_2,
  input  logic             ack_in_3,
  output logic             illegal,
  output logic [CNT_W-1:0] cnt_1,
  output logic [CNT_W-1:0] cnt_2,
  output logic [CNT_W-1:0] cnt_3
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StReq, StAck, StRel, StErr} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       req_q, req_d;
  logic             ack_q, ack_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt3_q, cnt3_d;

  logic       req_s;
  logic [2:0] ack_s;
  logic       ack_sel;
  logic [1:0] dec;

  // Map opcode to channel number; 0 means unrecognised.
  function automatic logic [1:0] decode_op(input logic [6:0] op);
    unique case (op)
      7'b1100011, 7'b1101111:                         decode_op = 2'd1;
      7'b0100011:                                     decode_op = 2'd2;
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000: decode_op = 2'd3;
      default:                                        decode_op = 2'd0;
    endcase
  endfunction

`ifdef DISPATCH_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  // Two-flop synchronisers for the handshake inputs; opcode is held stable upstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {ack_in_3, ack_in_2, ack_in_1, req_in};
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q[0];
  assign ack_s = sync2_q[3:1];
`else
  assign req_s = req_in;
  assign ack_s = {ack_in_3, ack_in_2, ack_in_1};
`endif

  assign dec = decode_op(opcode);

  // Acknowledge of the latched channel only; other channels are ignored.
  always_comb begin
    ack_sel = 1'b0;
    unique case (sel_q)
      2'd1:    ack_sel = ack_s[0];
      2'd2:    ack_sel = ack_s[1];
      2'd3:    ack_sel = ack_s[2];
      default: ack_sel = 1'b0;
    endcase
  end

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    req_d   = req_q;
    ack_d   = ack_q;
    ill_d   = ill_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    cnt3_d  = cnt3_q;
    unique case (state_q)
      StIdle: begin
        if (req_s) begin
          if (dec != 2'd0) begin
            state_d = StReq;
            sel_d   = dec;
            unique case (dec)
              2'd1:    req_d = 3'b001;
              2'd2:    req_d = 3'b010;
              default: req_d = 3'b100;
            endcase
          end else begin
            state_d = StErr;
            ack_d   = 1'b1;
            ill_d   = 1'b1;
          end
        end
      end
      StReq: begin
        if (ack_sel) begin
          state_d = StAck;
          ack_d   = 1'b1;
        end
      end
      StAck: begin
        if (!req_s) begin
          state_d = StRel;
          req_d   = 3'b000;
        end
      end
      StRel: begin
        // ack_out only drops once the channel has returned its ack to zero.
        if (!ack_sel) begin
          state_d = StIdle;
          ack_d   = 1'b0;
          sel_d   = 2'd0;
          unique case (sel_q)
            2'd1:    cnt1_d = cnt1_q + CntOne;
            2'd2:    cnt2_d = cnt2_q + CntOne;
            default: cnt3_d = cnt3_q + CntOne;
          endcase
        end
      end
      StErr: begin
        if (!req_s) begin
          state_d = StIdle;
          ack_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      req_q   <= 3'b000;
      ack_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      cnt3_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      ill_q   <= ill_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      cnt3_q  <= cnt3_d;
    end
  end

  assign req_out_1 = req_q[0];
  assign req_out_2 = req_q[1];
  assign req_out_3 = req_q[2];
  assign ack_out   = ack_q;
  assign illegal   = ill_q;
  assign cnt_1     = cnt1_q;
  assign cnt_2     = cnt2_q;
  assign cnt_3     = cnt3_q;

endmodule

// File: tb/tb_dispatch_3.sv
// Testbench for dispatch_3: randomized transactions checked against a behavioural model
// of the opcode routing and per-channel completion counts.
module tb_dispatch_3;

  localparam int unsigned CW  = 2;
  localparam int          MOD = 1 << CW;
`ifdef DISPATCH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          req_in;
  logic          ack_out;
  logic          req_out_1, req_out_2, req_out_3;
  logic          ack_in_1, ack_in_2, ack_in_3;
  logic          illegal;
  logic [CW-1:0] cnt_1, cnt_2, cnt_3;
  logic [4:0]    outs;

  int checks = 0;
  int errors = 0;
  int exp_cnt [1:3];
  int exp_ch = 0;
  bit mon_en = 1'b0;

  dispatch_3 #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .req_in    (req_in),
    .ack_out   (ack_out),
    .req_out_1 (req_out_1),
    .req_out_2 (req_out_2),
    .req_out_3 (req_out_3),
    .ack_in_1  (ack_in_1),
    .ack_in_2  (ack_in_2),
    .ack_in_3  (ack_in_3),
    .illegal   (illegal),
    .cnt_1     (cnt_1),
    .cnt_2     (cnt_2),
    .cnt_3     (cnt_3)
  );

  always #5 clk = ~clk;

  // Bit 0..2 = req_out_1..3, bit 3 = ack_out, bit 4 = illegal.
  assign outs = {illegal, ack_out, req_out_3, req_out_2, req_out_1};

  // Channel a given opcode must be routed to; 0 for unrecognised.
  function automatic int ref_chan(input logic [6:0] op);
    case (op)
      7'b1100011, 7'b1101111:                         return 1;
      7'b0100011:                                     return 2;
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000: return 3;
      default:                                        return 0;
    endcase
  endfunction

  // Only the channel the current transaction targets may ever see a request.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 1; k <= 3; k++) begin
        checks++;
        if (outs[k-1] === 1'b1 && k != exp_ch) begin
          errors++;
          $display("FAIL onehot: req_out_%0d=1 while expected channel=%0d", k, exp_ch);
        end
      end
    end
  end

  // Waits up to max cycles for outs[idx]==val; n = cycles taken, -1 on timeout.
  task automatic wait_for(input int idx, input logic val, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (outs[idx] === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_ack(input int ch, input logic v);
    case (ch)
      1: ack_in_1 = v;
      2: ack_in_2 = v;
      3: ack_in_3 = v;
      default: ;
    endcase
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (cnt_1 !== CW'(exp_cnt[1]) || cnt_2 !== CW'(exp_cnt[2]) || cnt_3 !== CW'(exp_cnt[3])) begin
      errors++;
      $display("FAIL %s counts: got %0d/%0d/%0d want %0d/%0d/%0d", tag, cnt_1, cnt_2, cnt_3,
               exp_cnt[1], exp_cnt[2], exp_cnt[3]);
    end
  endtask

  // One complete 4-phase transaction, legal or illegal, with given channel-side delay.
  task automatic do_txn(input logic [6:0] op, input int delay);
    int ch, n;
    ch = ref_chan(op);
    opcode = op;
    exp_ch = ch;
    req_in = 1'b1;
    if (ch == 0) begin
      wait_for(3, 1'b1, 20, n);
      checks++;
      if (n != LAT) begin errors++; $display("FAIL ill_ack_rise: latency %0d want %0d", n, LAT); end
      checks++;
      if (illegal !== 1'b1 || outs[2:0] !== 3'b000) begin
        errors++;
        $display("FAIL ill_flags: illegal=%b req=%b want 1/000", illegal, outs[2:0]);
      end
      repeat (delay) @(negedge clk);
      req_in = 1'b0;
      wait_for(3, 1'b0, 20, n);
      checks++;
      if (n != LAT || illegal !== 1'b0) begin
        errors++;
        $display("FAIL ill_release: latency %0d illegal=%b want %0d/0", n, illegal, LAT);
      end
    end else begin
      wait_for(ch - 1, 1'b1, 20, n);
      checks++;
      if (n != LAT) begin errors++; $display("FAIL req_rise ch%0d: latency %0d want %0d", ch, n, LAT); end
      repeat (delay) @(negedge clk);
      set_ack(ch, 1'b1);
      wait_for(3, 1'b1, 20, n);
      checks++;
      if (n != LAT) begin errors++; $display("FAIL ack_rise ch%0d: latency %0d want %0d", ch, n, LAT); end
      repeat (delay) @(negedge clk);
      req_in = 1'b0;
      wait_for(ch - 1, 1'b0, 20, n);
      checks++;
      if (n != LAT || ack_out !== 1'b1) begin
        errors++;
        $display("FAIL req_fall ch%0d: latency %0d ack_out=%b want %0d/1", ch, n, ack_out, LAT);
      end
      repeat (delay) @(negedge clk);
      set_ack(ch, 1'b0);
      wait_for(3, 1'b0, 20, n);
      checks++;
      if (n != LAT) begin errors++; $display("FAIL ack_fall ch%0d: latency %0d want %0d", ch, n, LAT); end
      exp_cnt[ch] = (exp_cnt[ch] + 1) % MOD;
    end
    check_counts("txn");
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    opcode = 7'b0110011;
    req_in = 1'b1;
    exp_ch = 3;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b want 00000", outs); end
    exp_cnt[1] = 0; exp_cnt[2] = 0; exp_cnt[3] = 0;
    check_counts("reset");
    mon_en = 1'b1;
    // Request already pending when reset releases.
    rst_n = 1'b1;
    wait_for(2, 1'b1, 20, n);
    checks++;
    if (n != LAT) begin errors++; $display("FAIL reset_release_dispatch: latency %0d want %0d", n, LAT); end
    ack_in_3 = 1'b1;
    wait_for(3, 1'b1, 20, n);
    req_in = 1'b0;
    wait_for(2, 1'b0, 20, n);
    ack_in_3 = 1'b0;
    wait_for(3, 1'b0, 20, n);
    checks++;
    if (n != LAT) begin errors++; $display("FAIL reset_release_done: latency %0d want %0d", n, LAT); end
    exp_cnt[3] = (exp_cnt[3] + 1) % MOD;
    check_counts("reset_release");
  endtask

  task automatic test_routing();
    do_txn(7'b1100011, 0);
    do_txn(7'b0100011, 1);
    do_txn(7'b0110011, 2);
  endtask

  task automatic test_ordering();
    int n;
    opcode = 7'b0110011;
    exp_ch = 3;
    req_in = 1'b1;
    wait_for(2, 1'b1, 20, n);
    ack_in_3 = 1'b1;
    wait_for(3, 1'b1, 20, n);
    req_in = 1'b0;
    wait_for(2, 1'b0, 20, n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ack_out !== 1'b1) begin errors++; $display("FAIL order_hold cycle %0d: ack_out=%b want 1", i, ack_out); end
    end
    ack_in_3 = 1'b0;
    wait_for(3, 1'b0, 20, n);
    checks++;
    if (n != LAT) begin errors++; $display("FAIL order_release: latency %0d want %0d", n, LAT); end
    exp_cnt[3] = (exp_cnt[3] + 1) % MOD;
    check_counts("ordering");
  endtask

  task automatic test_opcode_change();
    int n;
    opcode = 7'b0010011;
    exp_ch = 3;
    req_in = 1'b1;
    wait_for(2, 1'b1, 20, n);
    opcode = 7'b1101111;
    repeat (2) @(negedge clk);
    checks++;
    if (req_out_3 !== 1'b1 || req_out_1 !== 1'b0) begin
      errors++;
      $display("FAIL opchange_hold: req_out_3=%b req_out_1=%b want 1/0", req_out_3, req_out_1);
    end
    ack_in_3 = 1'b1;
    wait_for(3, 1'b1, 20, n);
    checks++;
    if (n != LAT) begin errors++; $display("FAIL opchange_ack: latency %0d want %0d", n, LAT); end
    req_in = 1'b0;
    wait_for(2, 1'b0, 20, n);
    ack_in_3 = 1'b0;
    wait_for(3, 1'b0, 20, n);
    exp_cnt[3] = (exp_cnt[3] + 1) % MOD;
    check_counts("opcode_change");
  endtask

  task automatic test_illegal();
    do_txn(7'b1111111, 0);
    do_txn(7'b1010101, 2);
  endtask

  task automatic test_stray_ack();
    exp_ch = 0;
    ack_in_1 = 1'b1; ack_in_2 = 1'b1; ack_in_3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 5'b0) begin errors++; $display("FAIL stray_ack cycle %0d: outs=%b want 00000", i, outs); end
    end
    ack_in_1 = 1'b0; ack_in_2 = 1'b0; ack_in_3 = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check_counts("stray_ack");
    do_txn(7'b1101111, 1);
  endtask

  task automatic test_abort();
    int n;
    opcode = 7'b0100011;
    exp_ch = 2;
    req_in = 1'b1;
    wait_for(1, 1'b1, 20, n);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b0) begin errors++; $display("FAIL abort_outs: got %b want 00000", outs); end
    exp_cnt[1] = 0; exp_cnt[2] = 0; exp_cnt[3] = 0;
    check_counts("abort");
    req_in = 1'b0;
    rst_n = 1'b1;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < MOD; i++) do_txn(7'b1100011, 0);
    checks++;
    if (cnt_1 !== CW'(0)) begin errors++; $display("FAIL wrap: cnt_1=%0d want 0", cnt_1); end
  endtask

  task automatic test_random();
    logic [6:0] pool [8];
    logic [6:0] op;
    pool = '{7'b1100011, 7'b1101111, 7'b0100011, 7'b0110011,
             7'b0010011, 7'b0000011, 7'b0000000, 7'b1111111};
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else op = pool[$urandom_range(0, 7)];
      do_txn(op, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; req_in = 1'b0;
    ack_in_1 = 1'b0; ack_in_2 = 1'b0; ack_in_3 = 1'b0;
    @(negedge clk);
    test_reset();
    test_routing();
    test_ordering();
    test_opcode_change();
    test_illegal();
    test_stray_ack();
    test_abort();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
